// File: rtl/i2c_slave_if.sv
// I2C slave with an RX byte memory written by master writes and a TX FIFO
// drained by master reads; bus inputs are synchronized into the clk_i domain.
module i2c_slave_if #(
  parameter int                        I2C_ADDR_WIDTH      = 7,
  parameter int                        I2C_DATA_WIDTH      = 8,
  parameter int                        TRANSFER_DEBUG_MODE = 0,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR          = 7'h12,
  parameter int                        BUF_DEPTH           = 128
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               scl_i,
  input  logic                               sda_i,
  output logic                               sda_o,
  input  logic [I2C_ADDR_WIDTH-1:0]          cfg_addr_i,
  input  logic                               cfg_load_i,
  input  logic                               tx_push_i,
  input  logic [I2C_DATA_WIDTH-1:0]          tx_data_i,
  input  logic [$clog2(BUF_DEPTH)-1:0]       rx_idx_i,
  output logic [I2C_DATA_WIDTH-1:0]          rx_data_o,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     rx_count_o,
  output logic [I2C_DATA_WIDTH-1:0]          most_recent_xfer
);
  localparam int DW = I2C_DATA_WIDTH;
  localparam int IW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH+1);
  localparam int BW = $clog2(DW+1);
  localparam logic [BW-1:0] LAST = BW'(DW);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
  localparam logic [IW-1:0] PTR_MAX = IW'(BUF_DEPTH-1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;
  localparam logic [2:0] S_IGNORE   = 3'd7;

  // Transfer printouts are produced by the bench; the flag carries no logic.
  if (TRANSFER_DEBUG_MODE != 0) begin : g_dbg
  end

  // [0] first flop, [1] synchronized value, [2] previous synchronized value
  logic [2:0] scl_sync, sda_sync;
  logic       start_c, stop_c, scl_rise, scl_fall, sda_s;

  logic [2:0]                state;
  logic [BW-1:0]             bit_cnt;
  logic [DW-1:0]             shift;
  logic [DW-2:0]             tx_shift;
  logic                      rw, mack;
  logic [I2C_ADDR_WIDTH-1:0] slave_addr;

  logic [DW-1:0] rx_mem [BUF_DEPTH];
  logic [DW-1:0] tx_mem [BUF_DEPTH];
  logic [IW-1:0] tx_wr, tx_rd;
  logic [CW-1:0] tx_cnt;

  logic          run, rx_we, load_rd, tx_pop, tx_push_ok, tx_empty, tx_full, addr_match;
  logic [DW-1:0] tx_byte;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_i};
      sda_sync <= {sda_sync[1:0], sda_i};
    end
  end

  always_comb begin
    sda_s    = sda_sync[1];
    start_c  = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
    stop_c   = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];
    scl_rise = scl_sync[1] & ~scl_sync[2];
    scl_fall = ~scl_sync[1] & scl_sync[2];
  end

  function automatic logic [IW-1:0] ptr_nxt(input logic [IW-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    run        = rst_i & ~cfg_load_i & ~start_c & ~stop_c;
    tx_empty   = (tx_cnt == '0);
    tx_full    = (tx_cnt == FULL);
    tx_byte    = tx_empty ? '1 : tx_mem[tx_rd];
    addr_match = (shift[DW-1 -: I2C_ADDR_WIDTH] == slave_addr);
    rx_we      = run & scl_fall & (state == S_WR_DATA) & (bit_cnt == LAST) & (rx_count_o < FULL);
    load_rd    = run & scl_fall & (((state == S_ADDR_ACK) & rw) | ((state == S_RD_ACK) & mack));
    tx_pop     = load_rd & ~tx_empty;
    tx_push_ok = rst_i & ~cfg_load_i & tx_push_i & ~tx_full;
    rx_data_o  = rx_mem[rx_idx_i];
  end

  always_ff @(posedge clk_i) begin
    if (rx_we) rx_mem[rx_count_o[IW-1:0]] <= shift;
    if (tx_push_ok) tx_mem[tx_wr] <= tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || cfg_load_i) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push_ok) tx_wr <= ptr_nxt(tx_wr);
      if (tx_pop)     tx_rd <= ptr_nxt(tx_rd);
      case ({tx_push_ok, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state            <= S_IDLE;
      sda_o            <= 1'b1;
      most_recent_xfer <= '0;
      rx_count_o       <= '0;
      slave_addr       <= SLAVE_ADDR;
      bit_cnt          <= '0;
      shift            <= '0;
      tx_shift         <= '0;
      rw               <= 1'b0;
      mack             <= 1'b0;
    end else if (cfg_load_i) begin
      slave_addr <= cfg_addr_i;
      rx_count_o <= '0;
      state      <= S_IDLE;
      sda_o      <= 1'b1;
    end else if (start_c) begin
      state   <= S_ADDR;
      bit_cnt <= '0;
      sda_o   <= 1'b1;
    end else if (stop_c) begin
      state <= S_IDLE;
      sda_o <= 1'b1;
    end else begin
      if (scl_rise && bit_cnt != LAST &&
          (state == S_ADDR || state == S_WR_DATA || state == S_RD_DATA)) begin
        shift   <= {shift[DW-2:0], sda_s};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (scl_rise && state == S_RD_ACK) mack <= ~sda_s;
      // sda_o only moves on a falling scl so the master never sees it change while scl is high
      if (scl_fall) begin
        case (state)
          S_ADDR: if (bit_cnt == LAST) begin
            if (addr_match) begin
              sda_o <= 1'b0;
              rw    <= shift[0];
              state <= S_ADDR_ACK;
            end else begin
              state <= S_IGNORE;
            end
          end
          S_ADDR_ACK: begin
            bit_cnt <= '0;
            if (rw) begin
              state            <= S_RD_DATA;
              sda_o            <= tx_byte[DW-1];
              tx_shift         <= tx_byte[DW-2:0];
              most_recent_xfer <= tx_byte;
            end else begin
              state <= S_WR_DATA;
              sda_o <= 1'b1;
            end
          end
          S_WR_DATA: if (bit_cnt == LAST) begin
            if (rx_count_o < FULL) begin
              rx_count_o       <= rx_count_o + 1'b1;
              most_recent_xfer <= shift;
              sda_o            <= 1'b0;
              state            <= S_WR_ACK;
            end else begin
              state <= S_IGNORE;
            end
          end
          S_WR_ACK: begin
            sda_o   <= 1'b1;
            bit_cnt <= '0;
            state   <= S_WR_DATA;
          end
          S_RD_DATA: begin
            if (bit_cnt == LAST) begin
              sda_o <= 1'b1;
              state <= S_RD_ACK;
            end else begin
              sda_o    <= tx_shift[DW-2];
              tx_shift <= {tx_shift[DW-3:0], 1'b0};
            end
          end
          S_RD_ACK: begin
            if (mack) begin
              bit_cnt          <= '0;
              state            <= S_RD_DATA;
              sda_o            <= tx_byte[DW-1];
              tx_shift         <= tx_byte[DW-2:0];
              most_recent_xfer <= tx_byte;
            end else begin
              state <= S_IGNORE;
              sda_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_if.sv
// Bit-banged I2C master against i2c_slave_if; a queue model predicts every
// ACK bit, read byte and status value, and a monitor process checks them.
module tb_i2c_slave_if;
  localparam int DEPTH = 128;
  localparam int Q     = 4;

  logic       clk_i = 1'b0, rst_i = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       sda_o, sda_bus;
  logic [6:0] cfg_addr_i = '0;
  logic       cfg_load_i = 1'b0, tx_push_i = 1'b0;
  logic [7:0] tx_data_i = '0;
  logic [6:0] rx_idx_i = '0;
  logic [7:0] rx_data_o, most_recent_xfer;
  logic [7:0] rx_count_o;

  assign sda_bus = sda_m & sda_o;

  i2c_slave_if dut (
    .clk_i(clk_i), .rst_i(rst_i), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
    .cfg_addr_i(cfg_addr_i), .cfg_load_i(cfg_load_i),
    .tx_push_i(tx_push_i), .tx_data_i(tx_data_i),
    .rx_idx_i(rx_idx_i), .rx_data_o(rx_data_o), .rx_count_o(rx_count_o),
    .most_recent_xfer(most_recent_xfer)
  );

  always #5 clk_i = ~clk_i;

  // reference model
  logic [7:0] rx_m[$], tx_m[$];
  logic [6:0] m_addr = 7'h12;
  logic [7:0] m_mrx = '0;
  logic       m_ign = 1'b0;

  typedef struct { string nm; logic [31:0] val; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int checks = 0, errors = 0;

  task automatic expect_v(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic obs(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      while (obs_q.size() > 0) begin
        logic [31:0] a;
        exp_t e;
        a = obs_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got 0x%0h, no expectation queued", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e.val) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", e.nm, a, e.val);
          end
        end
      end
    end
  end

  task automatic qw; repeat (Q) @(negedge clk_i); endtask
  task automatic m_start; sda_m = 1; qw; scl_m = 1; qw; sda_m = 0; qw; scl_m = 0; qw; endtask
  task automatic m_stop;  sda_m = 0; qw; scl_m = 1; qw; sda_m = 1; qw; endtask
  task automatic send_bit(input logic b); sda_m = b; qw; scl_m = 1; qw; qw; scl_m = 0; qw; endtask
  task automatic recv_bit(output logic b); sda_m = 1; qw; scl_m = 1; qw; b = sda_bus; qw; scl_m = 0; qw; endtask

  task automatic wr_byte(input logic [7:0] d);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(a);
    obs({31'b0, a});
  endtask

  task automatic rd_byte(input logic nack);
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack);
    obs({24'b0, d});
  endtask

  task automatic m_addr_byte(input logic [7:0] b);
    m_ign = (b[7:1] != m_addr);
    expect_v("addr_ack", {31'b0, m_ign});
    wr_byte(b);
  endtask

  task automatic m_write(input logic [7:0] b);
    if (m_ign) expect_v("wr_ack", 1);
    else if (rx_m.size() >= DEPTH) begin
      expect_v("wr_ack", 1);
      m_ign = 1'b1;
    end else begin
      rx_m.push_back(b);
      m_mrx = b;
      expect_v("wr_ack", 0);
    end
    wr_byte(b);
  endtask

  task automatic m_read(input logic nack);
    logic [7:0] v;
    v = (tx_m.size() > 0) ? tx_m.pop_front() : 8'hFF;
    m_mrx = v;
    expect_v("rd_data", {24'b0, v});
    rd_byte(nack);
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge clk_i);
    tx_push_i = 1'b1; tx_data_i = b;
    @(negedge clk_i);
    tx_push_i = 1'b0;
    if (tx_m.size() < DEPTH) tx_m.push_back(b);
  endtask

  task automatic chk_mrx;
    expect_v("most_recent_xfer", {24'b0, m_mrx});
    obs({24'b0, most_recent_xfer});
  endtask

  task automatic chk_status;
    @(negedge clk_i);
    expect_v("rx_count", rx_m.size());
    obs({24'b0, rx_count_o});
    chk_mrx();
    expect_v("sda_released", 1);
    obs({31'b0, sda_o});
  endtask

  task automatic chk_mem;
    for (int i = 0; i < rx_m.size(); i++) begin
      @(negedge clk_i);
      rx_idx_i = 7'(i);
      #1;
      expect_v("rx_mem", {24'b0, rx_m[i]});
      obs({24'b0, rx_data_o});
    end
  endtask

  task automatic model_clear;
    rx_m.delete();
    tx_m.delete();
    m_mrx = '0;
  endtask

  initial begin
    #1500us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk_status();

    // 32-byte write burst
    m_start(); m_addr_byte(8'h24);
    for (int i = 0; i < 32; i++) m_write(8'(i));
    m_stop(); chk_status(); chk_mem();

    // 32-byte read burst, last byte NACKed
    for (int i = 100; i < 132; i++) push_tx(8'(i));
    m_start(); m_addr_byte(8'h25);
    for (int i = 0; i < 32; i++) m_read(i == 31);
    m_stop(); chk_status();

    // foreign address must not touch RX memory or TX FIFO
    push_tx(8'hA5);
    m_start(); m_addr_byte(8'h26); m_write(8'h77);
    m_stop(); chk_status();

    // queued byte, then empty FIFO returns 0xFF
    m_start(); m_addr_byte(8'h25); m_read(1'b0); m_read(1'b1);
    m_stop(); chk_status();

    // alternating write / repeated START / read
    m_start();
    for (int k = 0; k < 64; k++) begin
      b = 8'($urandom);
      m_addr_byte(8'h24); m_write(b); chk_mrx();
      if ($urandom_range(0, 1) == 1) push_tx(8'($urandom));
      m_start(); m_addr_byte(8'h25); m_read(1'b1); chk_mrx();
      m_start();
    end
    m_stop(); chk_status(); chk_mem();

    // fill RX memory to capacity, further bytes NACKed and discarded
    m_start(); m_addr_byte(8'h24);
    for (int k = 0; k < 34; k++) m_write(8'($urandom));
    m_stop(); chk_status();

    // new address load clears both buffers
    push_tx(8'h11);
    @(negedge clk_i);
    cfg_addr_i = 7'h33; cfg_load_i = 1'b1;
    @(negedge clk_i);
    cfg_load_i = 1'b0;
    m_addr = 7'h33;
    rx_m.delete(); tx_m.delete();
    chk_status();
    m_start(); m_addr_byte(8'h66); m_write(8'h5A);
    m_start(); m_addr_byte(8'h67); m_read(1'b1);
    m_start(); m_addr_byte(8'h24);
    m_stop(); chk_status(); chk_mem();

    // reset while the slave holds the address ACK low
    m_start();
    b = 8'h66;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    expect_v("ack_driven_low", 0);
    obs({31'b0, sda_o});
    rst_i = 1'b0;
    @(negedge clk_i);
    expect_v("sda_after_reset", 1);
    obs({31'b0, sda_o});
    expect_v("rx_count_after_reset", 0);
    obs({24'b0, rx_count_o});
    rst_i = 1'b1;
    m_addr = 7'h12;
    model_clear();
    repeat (4) @(negedge clk_i);
    m_stop();
    m_start(); m_addr_byte(8'h24); m_write(8'hC3);
    m_stop(); chk_status(); chk_mem();

    repeat (20) @(posedge clk_i);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: no output observed, expected 0x%0h", e.nm, e.val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_if.md
I2C_SLAVE_IF -- requirements
Module: i2c_slave_if

Interface
- REQ-001 SHALL have parameter I2C_ADDR_WIDTH, default 7: slave address width.
- REQ-002 SHALL have parameter I2C_DATA_WIDTH, default 8: data byte width.
- REQ-003 SHALL have parameter TRANSFER_DEBUG_MODE, default 0: when 1, simulation-only transfer printouts; no effect on logic.
- REQ-004 SHALL have parameter SLAVE_ADDR, default 7'h12: address loaded at reset.
- REQ-005 SHALL have parameter BUF_DEPTH, default 128: depth of TX FIFO and of RX memory.
- REQ-006 clk_i  in  1  system clock; one clock domain.
- REQ-007 rst_i  in  1  reset; synchronous, active-low.
- REQ-008 scl_i  in  1  I2C clock as seen on the bus.
- REQ-009 sda_i  in  1  I2C data as seen on the bus.
- REQ-010 sda_o  out  1  open-drain data drive: 0 pulls low, 1 releases.
- REQ-011 cfg_addr_i  in  7  new slave address; cfg_load_i  in  1  loads cfg_addr_i and clears both buffers.
- REQ-012 tx_push_i  in  1  and tx_data_i  in  8  push one byte into the TX FIFO.
- REQ-013 rx_idx_i  in  7  RX memory index; rx_data_o  out  8  combinational entry at rx_idx_i; rx_count_o  out  8  number of bytes stored.
- REQ-014 most_recent_xfer  out  8  last byte received from, or sent to, the master.

Function
- REQ-015 scl_i/sda_i SHALL pass through 2-FF synchronizers; edges are detected on the synchronized values.
- REQ-016 START (sda falling while scl high) SHALL enter ADDR from any state, including repeated START.
- REQ-017 STOP (sda rising while scl high) SHALL enter IDLE from any state and release sda_o.
- REQ-018 Bits SHALL be sampled on scl rising edge, MSB first; sda_o changes only after scl falling edge.
- REQ-019 States SHALL be: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- REQ-020 ADDR: after 8 bits, if byte[7:1]==slave address, SHALL drive sda_o=0 from the 8th falling edge to the 9th falling edge (ADDR_ACK).
- REQ-021 ADDR mismatch SHALL leave sda_o=1 (NACK) and go to IGNORE until next START or STOP.
- REQ-022 After ADDR_ACK: byte[0]=0 goes to WR_DATA; byte[0]=1 goes to RD_DATA.
- REQ-023 WR_DATA: each 8-bit byte SHALL be written to RX memory at rx_count_o, rx_count_o increments, most_recent_xfer updates, and the byte is ACKed in WR_ACK.
- REQ-024 When rx_count_o==BUF_DEPTH, a written byte SHALL be NACKed and discarded; state goes to IGNORE.
- REQ-025 RD_DATA: on entry, the slave SHALL pop the TX FIFO head and drive its 8 bits, then release sda_o for the 9th bit; most_recent_xfer updates to the byte sent.
- REQ-026 If the TX FIFO is empty, 8'hFF SHALL be sent and nothing popped.
- REQ-027 RD_ACK: master ACK (sda=0 on 9th rising edge) SHALL return to RD_DATA with the next byte; NACK SHALL go to IGNORE with sda_o released.
- REQ-028 tx_push_i when the FIFO holds BUF_DEPTH bytes SHALL be ignored; a push and pop in the same cycle are both performed.
- REQ-029 cfg_load_i during an active transfer SHALL take effect immediately and force IDLE.
- REQ-030 Reset, cfg_load_i, and all state transitions SHALL take effect on the clk_i rising edge.

Reset
- REQ-031 While rst_i=0 at a clk_i rising edge: state=IDLE, sda_o=1, most_recent_xfer=0, rx_count_o=0, TX FIFO empty, slave address=SLAVE_ADDR.
- REQ-032 Reset mid-transfer SHALL abort the transfer: sda_o is released within one clock and the slave waits for a new START.

Verification
- REQ-033 START, address byte 0x24, 32 data bytes 0..31, STOP -> every byte ACKed, rx_count_o=32, entries 0..31 equal 0..31.
- REQ-034 Push 100..131; START, address byte 0x25, 31 reads with ACK and 1 read with NACK, STOP -> master receives 100..131, sda_o released after the final byte.
- REQ-035 Alternating sequence 64 times: write one byte, repeated START, read one byte -> RX memory and read data are in order, and most_recent_xfer tracks each byte.
- REQ-036 Address byte 0x26 (address 0x13) -> NACK on the 9th clock; no change to RX memory or TX FIFO.
- REQ-037 Read with the TX FIFO empty -> 0xFF is returned.
- REQ-038 rst_i=0 asserted while sda_o=0 during an ACK -> sda_o=1 on the next clock; rx_count_o=0.
